// File: rtl/dcache_pkg.sv
// Shared widths, geometry and FSM state encoding for the data cache.
// Ports: none (package).
// Imported by dcache_storage and dcache_controller.
package dcache_pkg;

    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int BLOCK_W     = 32;
    localparam int SETS        = 8;
    localparam int BLOCK_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_storage.sv
// Line arrays (valid/dirty/tag/data) with byte-write and whole-line fill ports.
// Ports: index/tag/offset select the line; wr_en writes one byte and sets dirty;
// fill_en loads a block, sets tag and valid, and clears dirty; hit, the line fields and rd_byte are combinational.
module dcache_storage
    import dcache_pkg::*;
#(
    parameter int N_SETS    = SETS,
    parameter int N_BYTES   = BLOCK_BYTES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_W-1:0]     index,
    input  logic [TAG_W-1:0]       tag,
    input  logic [OFFSET_W-1:0]    offset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_byte,
    input  logic                   fill_en,
    input  logic [N_BYTES*8-1:0]   fill_data,
    output logic                   hit,
    output logic                   line_valid,
    output logic                   line_dirty,
    output logic [TAG_W-1:0]       line_tag,
    output logic [N_BYTES*8-1:0]   line_data,
    output logic [7:0]             rd_byte
);

    logic [N_SETS-1:0]          valid_q, valid_d;
    logic [N_SETS-1:0]          dirty_q, dirty_d;
    logic [TAG_W-1:0]           tag_q  [N_SETS];
    logic [TAG_W-1:0]           tag_d  [N_SETS];
    logic [N_BYTES*8-1:0]       data_q [N_SETS];
    logic [N_BYTES*8-1:0]       data_d [N_SETS];

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];
    assign hit        = valid_q[index] && (tag_q[index] == tag);
    // Byte select does not depend on hit; the CPU only consumes it when not stalled.
    assign rd_byte    = data_q[index][{offset, 3'b000} +: 8];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
            tag_d[index]   = tag;
            data_d[index]  = fill_data;
        end else if (wr_en) begin
            dirty_d[index] = 1'b1;
            data_d[index][{offset, 3'b000} +: 8] = wr_byte;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < N_SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache: zero-stall hits, miss handling FSM.
// Ports: CPU side cpu_read/cpu_write/cpu_address/cpu_writedata -> cpu_readdata/cpu_busywait;
// memory side mem_read/mem_write/mem_address/mem_writedata (registered) <- mem_readdata/mem_busywait.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cpu_read,
    input  logic                       cpu_write,
    input  logic [7:0]                 cpu_address,
    input  logic [7:0]                 cpu_writedata,
    output logic [7:0]                 cpu_readdata,
    output logic                       cpu_busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [TAG_W+INDEX_W-1:0]   mem_address,
    output logic [BLOCK_BYTES*8-1:0]   mem_writedata,
    input  logic [BLOCK_BYTES*8-1:0]   mem_readdata,
    input  logic                       mem_busywait
);

    state_e                      state_q, state_d;
    logic                        mem_read_q, mem_read_d;
    logic                        mem_write_q, mem_write_d;
    logic [TAG_W+INDEX_W-1:0]    mem_address_q, mem_address_d;
    logic [BLOCK_BYTES*8-1:0]    mem_writedata_q, mem_writedata_d;

    logic [TAG_W-1:0]            req_tag;
    logic [INDEX_W-1:0]          req_index;
    logic [OFFSET_W-1:0]         req_offset;
    logic                        access;
    logic                        wr_en;
    logic                        fill_en;
    logic                        hit;
    logic                        line_valid;
    logic                        line_dirty;
    logic [TAG_W-1:0]            line_tag;
    logic [BLOCK_BYTES*8-1:0]    line_data;

    assign req_tag    = cpu_address[7:5];
    assign req_index  = cpu_address[4:2];
    assign req_offset = cpu_address[1:0];
    // Read and write together is treated as no request at all.
    assign access     = cpu_read ^ cpu_write;

    dcache_storage #(
        .N_SETS  (SETS),
        .N_BYTES (BLOCK_BYTES)
    ) u_storage (
        .clock      (clock),
        .reset      (reset),
        .index      (req_index),
        .tag        (req_tag),
        .offset     (req_offset),
        .wr_en      (wr_en),
        .wr_byte    (cpu_writedata),
        .fill_en    (fill_en),
        .fill_data  (mem_readdata),
        .hit        (hit),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .rd_byte    (cpu_readdata)
    );

    always_comb begin
        state_d         = state_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        cpu_busywait    = 1'b1;
        wr_en           = 1'b0;
        fill_en         = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_busywait = access && !hit;
                wr_en        = access && cpu_write && hit;
                if (access && !hit) begin
                    if (line_valid && line_dirty) begin
                        state_d         = WRITEBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {line_tag, req_index};
                        mem_writedata_d = line_data;
                    end else begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = {req_tag, req_index};
                    end
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    state_d       = FETCH;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = {req_tag, req_index};
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    state_d    = UPDATE;
                    mem_read_d = 1'b0;
                end
            end
            UPDATE: begin
                // Line fill; the held CPU access then completes as a hit in IDLE.
                fill_en = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 5-cycle-busy block memory model.
// Ports: none (top-level bench).
// Memory raises busywait with each request and drops it after 5 cycles.
module tb_dcache_controller;

    logic        clock;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [7:0]  cpu_writedata;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int n_checks = 0;
    int n_errors = 0;
    int overlap  = 0;

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model
    logic [31:0] mem [64];
    logic [2:0]  busy_cnt;

    function automatic logic [31:0] mem_init(input int a);
        case (a)
            8'h00:   return 32'h44332211;
            8'h08:   return 32'h88776655;
            8'h11:   return 32'hDDCCBBAA;
            8'h19:   return 32'h12345678;
            default: return 32'h0;
        endcase
    endfunction

    assign mem_busywait = (mem_read || mem_write) && (busy_cnt < 3'd5);
    assign mem_readdata = mem[mem_address];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cnt <= 3'd0;
            for (int i = 0; i < 64; i++) mem[i] <= mem_init(i);
        end else if ((mem_read || mem_write) && !mem_busywait) begin
            if (mem_write) mem[mem_address] <= mem_writedata;
            busy_cnt <= 3'd0;
        end else if (mem_read || mem_write) begin
            busy_cnt <= busy_cnt + 3'd1;
        end else begin
            busy_cnt <= 3'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one CPU access (called just after a falling edge), holds it until
    // cpu_busywait is low, records the memory traffic seen along the way.
    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output int stall,
                          output logic rd_seen, output logic [5:0] rd_addr,
                          output logic wr_seen, output logic [5:0] wr_addr,
                          output logic [31:0] wr_data, output logic [7:0] rdata);
        cpu_read      = rd;
        cpu_write     = wr;
        cpu_address   = addr;
        cpu_writedata = wdata;
        stall   = 0;
        rd_seen = 1'b0;
        rd_addr = '0;
        wr_seen = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        #1;
        while (cpu_busywait && stall < 100) begin
            @(negedge clock);
            stall++;
            if (mem_read && mem_write) overlap++;
            if (mem_read && !rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = mem_address;
            end
            if (mem_write && !wr_seen) begin
                wr_seen = 1'b1;
                wr_addr = mem_address;
                wr_data = mem_writedata;
            end
        end
        check("no_timeout", 32'(stall < 100), 32'd1);
        rdata = cpu_readdata;
        @(negedge clock);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    int          st;
    logic        rs, ws;
    logic [5:0]  ra, wa;
    logic [31:0] wd;
    logic [7:0]  rb;

    initial begin
        reset         = 1'b1;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = 8'h00;
        cpu_writedata = 8'h00;
        #1;
        check("rst_mem_read",      32'(mem_read),      32'd0);
        check("rst_mem_write",     32'(mem_write),     32'd0);
        check("rst_mem_address",   32'(mem_address),   32'd0);
        check("rst_mem_writedata", mem_writedata,      32'd0);
        check("rst_busywait",      32'(cpu_busywait),  32'd0);
        check("rst_readdata",      32'(cpu_readdata),  32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Clean read miss on 0x00
        access(1'b1, 1'b0, 8'h00, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("miss00_stall",   32'(st), 32'd8);
        check("miss00_rd_seen", 32'(rs), 32'd1);
        check("miss00_rd_addr", 32'(ra), 32'h00);
        check("miss00_no_wb",   32'(ws), 32'd0);
        check("miss00_data",    32'(rb), 32'h11);

        // Read hit 0x02
        access(1'b1, 1'b0, 8'h02, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("hit02_stall", 32'(st), 32'd0);
        check("hit02_data",  32'(rb), 32'h33);

        // Write hit 0x01
        access(1'b0, 1'b1, 8'h01, 8'hAB, st, rs, ra, ws, wa, wd, rb);
        check("wrhit01_stall", 32'(st), 32'd0);
        check("wrhit01_noreq", 32'(rs | ws), 32'd0);
        access(1'b1, 1'b0, 8'h01, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("rd01_stall", 32'(st), 32'd0);
        check("rd01_data",  32'(rb), 32'hAB);

        // Dirty miss on 0x20: writeback of line 0 then fetch of block 0x08
        access(1'b1, 1'b0, 8'h20, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("miss20_stall",   32'(st), 32'd14);
        check("miss20_wb_seen", 32'(ws), 32'd1);
        check("miss20_wb_addr", 32'(wa), 32'h00);
        check("miss20_wb_data", wd,      32'h4433AB11);
        check("miss20_rd_addr", 32'(ra), 32'h08);
        check("miss20_data",    32'(rb), 32'h55);
        check("miss20_memwb",   mem[0],  32'h4433AB11);

        // Write miss on invalid line: 0x47 -> fetch block 0x11, then write byte3
        access(1'b0, 1'b1, 8'h47, 8'h5C, st, rs, ra, ws, wa, wd, rb);
        check("wmiss47_stall",   32'(st), 32'd8);
        check("wmiss47_no_wb",   32'(ws), 32'd0);
        check("wmiss47_rd_addr", 32'(ra), 32'h11);
        access(1'b1, 1'b0, 8'h47, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("rd47_stall", 32'(st), 32'd0);
        check("rd47_data",  32'(rb), 32'h5C);
        access(1'b1, 1'b0, 8'h46, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("rd46_data",  32'(rb), 32'hCC);

        // Evicting line 1 shows it was dirty with byte3 = 0x5C
        access(1'b1, 1'b0, 8'h67, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("miss67_wb_seen", 32'(ws), 32'd1);
        check("miss67_wb_addr", 32'(wa), 32'h11);
        check("miss67_wb_data", wd,      32'h5CCCBBAA);
        check("miss67_rd_addr", 32'(ra), 32'h19);
        check("miss67_data",    32'(rb), 32'h12);

        // Read and write together: no access
        cpu_read      = 1'b1;
        cpu_write     = 1'b1;
        cpu_address   = 8'h64;
        cpu_writedata = 8'hEE;
        #1;
        check("both_busywait", 32'(cpu_busywait), 32'd0);
        @(negedge clock);
        check("both_noreq", 32'(mem_read | mem_write), 32'd0);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        access(1'b1, 1'b0, 8'h64, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("rd64_stall", 32'(st), 32'd0);
        check("rd64_data",  32'(rb), 32'h78);

        // Reset during FETCH (line 0 holds tag 1, clean)
        cpu_read    = 1'b1;
        cpu_address = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("fetch_mem_read", 32'(mem_read),    32'd1);
        check("fetch_mem_addr", 32'(mem_address), 32'h00);
        #2;
        reset    = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("rstmid_mem_read", 32'(mem_read),     32'd0);
        check("rstmid_busywait", 32'(cpu_busywait), 32'd0);
        check("rstmid_mem_addr", 32'(mem_address),  32'd0);
        @(negedge clock);
        reset = 1'b0;
        access(1'b1, 1'b0, 8'h00, 8'h00, st, rs, ra, ws, wa, wd, rb);
        check("rerd00_stall",   32'(st), 32'd8);
        check("rerd00_rd_seen", 32'(rs), 32'd1);
        check("rerd00_rd_addr", 32'(ra), 32'h00);
        check("rerd00_data",    32'(rb), 32'h11);

        check("no_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU datapath and the 32-bit-block data memory. It serves byte reads and writes from the CPU without stalling on a hit. On a miss it stalls the CPU through `cpu_busywait` and runs the memory read/write/busywait handshake as the initiator: dirty-block writeback first, then block fetch. It is the requester side of the data memory's interface.

## Interface
- `SETS`, 8: number of cache lines; fixed by the 3-bit index.
- `BLOCK_BYTES`, 4: bytes per line; matches the memory's 32-bit word.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cpu_read`  in  1  CPU byte read request, held until `cpu_busywait` is low.
- `cpu_write`  in  1  CPU byte write request, held until `cpu_busywait` is low.
- `cpu_address`  in  8  byte address: [7:5] tag, [4:2] index, [1:0] offset.
- `cpu_writedata`  in  8  write byte.
- `cpu_readdata`  out  8  selected byte of the indexed line; combinational.
- `cpu_busywait`  out  1  CPU stall.
- `mem_read`  out  1  block fetch request.
- `mem_write`  out  1  block writeback request.
- `mem_address`  out  6  block address, {tag, index}.
- `mem_writedata`  out  32  block to write; byte0 is in [7:0].
- `mem_readdata`  in  32  fetched block; byte0 is in [7:0].
- `mem_busywait`  in  1  memory busy.

## Operation
- Per line: `valid`, `dirty`, 3-bit tag, 32-bit data.
- `hit` = `valid[index]` and tag equal; combinational.
- An access is `cpu_read` XOR `cpu_write`. Both high, or both low, is no access: no stall and no memory request.
- FSM has four states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: `cpu_busywait` = 0 and the byte is on `cpu_readdata`.
  - Write hit: `cpu_busywait` = 0. At the clock edge, write the byte at the offset and set `dirty`.
  - Miss: `cpu_busywait` = 1. Go to WRITEBACK if `valid` and `dirty`, otherwise go to FETCH.
- WRITEBACK:
  - Drive `mem_write` = 1, `mem_address` = {stored tag, index}, `mem_writedata` = line data.
  - Go to FETCH on the first clock edge after entry where `mem_busywait` is 0.
- FETCH:
  - Drive `mem_read` = 1, `mem_address` = {request tag, index}.
  - Go to UPDATE on the first clock edge after entry where `mem_busywait` is 0.
- UPDATE:
  - No memory request.
  - At the clock edge, load the line from `mem_readdata` and set the tag, `valid` = 1, `dirty` = 0.
  - Go to IDLE. The pending CPU access then completes there as a hit. A write miss therefore allocates first, then the byte is written and `dirty` is set.
- `cpu_busywait` is 1 in every non-IDLE state.
- `mem_read` and `mem_write` are never high together. Both are 0 in IDLE and UPDATE.
- In IDLE and UPDATE, `mem_address` and `mem_writedata` hold their last values.

## Timing
- Reset (asynchronous): state goes to IDLE. All `valid` and `dirty` bits clear; data and tags clear to 0. `mem_read` = `mem_write` = 0, `mem_address` = 0, `mem_writedata` = 0. `cpu_busywait` = 0 unless an access is present, in which case it is a miss. `cpu_readdata` = 0.
- Hit latency is 0 stall cycles.
- Clean miss: FETCH (N cycles, until `mem_busywait` is low) + UPDATE (1) + the IDLE hit cycle.
- Dirty miss: adds WRITEBACK (M cycles) before FETCH.
- Request outputs are registered by state. They rise one clock edge after the miss is detected and fall on the edge that exits the state.
- The CPU must hold `cpu_address` and `cpu_writedata` stable while `cpu_busywait` = 1. The controller relies on this and does not latch them.
- Reset mid-miss: memory requests drop immediately and the in-flight block is discarded. The same address misses again after reset.
- The FSM ignores `mem_busywait` in IDLE and UPDATE.

## Structure
- Shared package `dcache_pkg`:
  - `TAG_W` = 3, `INDEX_W` = 3, `OFFSET_W` = 2, `BLOCK_W` = 32.
  - State encoding: IDLE = 2'd0, WRITEBACK = 2'd1, FETCH = 2'd2, UPDATE = 2'd3.
- One sub-module, `dcache_storage`: the valid/dirty/tag/data arrays, byte-write and line-fill ports, combinational hit and byte select.
- The FSM and memory-side outputs stay in `dcache_controller`.

## Test plan
The bench uses a memory model whose `mem_busywait` rises with the request and falls after 5 cycles.
- After reset, read 0x00 with memory block 0x00 = 0x44332211 -> `mem_read`, `mem_address` 0x00; `cpu_readdata` 0x11, then `cpu_busywait` low. A following read of 0x02 returns 0x33 with zero stall.
- Write 0xAB to 0x01 (hit) -> no stall and no memory request. A read of 0x01 returns 0xAB.
- Then read 0x20 -> `mem_write`, `mem_address` 0x00, `mem_writedata` 0x4433AB11; then `mem_read`, `mem_address` 0x08.
- Write 0x5C to 0x47 on an invalid line -> no writeback; `mem_read`, `mem_address` 0x11. The line then has byte3 = 0x5C and `dirty` = 1.
- Assert reset during FETCH -> `mem_read` and `cpu_busywait` fall without waiting for a clock edge. Reading the same address afterwards misses again.
- `cpu_read` = `cpu_write` = 1 -> `cpu_busywait` 0, no memory request, no line change.
